// File: rtl/seq_divider.sv
// Restoring shift-subtract divider producing one quotient bit per clock, with start/done handshake.
// Optional signed (two's complement) mode is enabled with the DIVIDER_SIGNED_EN macro.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_ext;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic [WIDTH-1:0] dvd_cap;
    logic [WIDTH-1:0] dvs_cap;
    logic             accept;

`ifdef DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic ovf_pend_q, ovf_pend_d;
    logic ovf_q, ovf_d;

    // Run the unsigned core on magnitudes; signs are restored when the result is registered.
    always_comb begin
        dvd_cap = dividend[WIDTH-1] ? WIDTH'(0) - dividend : dividend;
        dvs_cap = divisor[WIDTH-1]  ? WIDTH'(0) - divisor  : divisor;
        q_final = qneg_q ? WIDTH'(0) - dvd_next : dvd_next;
        r_final = rneg_q ? WIDTH'(0) - rem_next : rem_next;
    end
`else
    always_comb begin
        dvd_cap = dividend;
        dvs_cap = divisor;
        q_final = dvd_next;
        r_final = rem_next;
    end
`endif

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        rem_ext  = {rem_q, dvd_q[WIDTH-1]};
        diff     = rem_ext - {1'b0, dvs_q};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : rem_ext[WIDTH-1:0];
        dvd_next = {dvd_q[WIDTH-2:0], q_bit};
        accept   = start && (state_q != RUN);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
`ifdef DIVIDER_SIGNED_EN
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        ovf_pend_d  = ovf_pend_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            RUN: begin
                rem_d = rem_next;
                dvd_d = dvd_next;
                if (cnt_q == CW'(0)) begin
                    state_d     = DONE;
                    quotient_d  = q_final;
                    remainder_d = r_final;
                    dbz_d       = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    ovf_d       = ovf_pend_q;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    rem_d = '0;
                    dvd_d = dvd_cap;
                    dvs_d = dvs_cap;
`ifdef DIVIDER_SIGNED_EN
                    qneg_d     = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d     = dividend[WIDTH-1];
                    ovf_pend_d = (dividend == MIN_VAL) && (divisor == '1);
`endif
                    if (divisor == '0) begin
                        // Divide by zero skips the core and reports immediately.
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
`ifdef DIVIDER_SIGNED_EN
                        ovf_d       = 1'b0;
`endif
                    end else begin
                        state_d = RUN;
                        cnt_d   = CW'(WIDTH - 1);
                    end
                end
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            ovf_pend_q  <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            ovf_pend_q  <= ovf_pend_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    assign overflow    = ovf_q;
`else
    assign overflow    = 1'b0;
`endif

endmodule
